// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. Lookup is purely combinational from pc_if. Updates
//   arrive from EX and take effect at the next rising edge, so a lookup and
//   an update to the same index in one cycle sees the old entry.
//
// Ports
//   clk            core clock, all state changes on the rising edge
//   rst            asynchronous active-low reset
//   pc_if          PC of the instruction in IF
//   btb_hit        pc_if entry valid and tag matches
//   pred_taken     predict taken for pc_if
//   pred_target    predicted next PC (stored target, or pc_if + 4)
//   upd_valid      a branch resolves in EX this cycle
//   upd_pc         PC of the resolving branch
//   upd_taken      actual outcome
//   upd_target     actual target
//   upd_pred_taken prediction made for this branch back in IF
//   clear          synchronous invalidate of the whole table (wins over update)
//   stat_br_cnt    saturating count of resolved branches
//   stat_miss_cnt  saturating count of mispredicted branches
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRY_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        btb_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic        clear,
    output logic [31:0] stat_br_cnt,
    output logic [31:0] stat_miss_cnt
);

    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_W   = 30 - ENTRY_BITS;

    // Per-entry state. valid and counters are reset; tags and targets are not.
    logic [ENTRIES-1:0]       valid_q;
    logic [ENTRIES-1:0][1:0]  ctr_q;
    logic [TAG_W-1:0]         tag_q    [ENTRIES];
    logic [31:0]              target_q [ENTRIES];

    logic [ENTRY_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic [ENTRY_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    logic [1:0]            upd_ctr;
    logic [1:0]            ctr_next;
    logic                  mispredict;
    logic                  payload_we;
    logic                  unused_pc_bits;

    assign if_idx  = pc_if[ENTRY_BITS+1:2];
    assign if_tag  = pc_if[31:ENTRY_BITS+2];
    assign upd_idx = upd_pc[ENTRY_BITS+1:2];
    assign upd_tag = upd_pc[31:ENTRY_BITS+2];

    // Instructions are word aligned; the low PC bits of the update carry no information.
    assign unused_pc_bits = ^upd_pc[1:0];

    // ---------------- lookup (zero latency, no bypass from the update port) ----
    assign btb_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = btb_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : pc_if + 32'd4;

    // ---------------- update side -------------------------------------------
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr = ctr_q[upd_idx];

    always_comb begin
        // NOTE: default assigned first so every path drives ctr_next and no latch is inferred.
        ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'd1;
        end
    end

    // Wrong direction, or right "taken" call with a stale stored target.
    // The stored target only means something when the entry actually hits.
    assign mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_pred_taken && upd_taken && upd_hit &&
                         (target_q[upd_idx] != upd_target));

    // Tag/target writes: taken update that hits (retarget) or misses (allocate).
    assign payload_we = rst && upd_valid && !clear && upd_taken;

    // Control state: valid bits and direction counters.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
        end else if (clear) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'b10;
            end
        end
    end

    // NOTE: tag/target storage has no reset; a cleared valid bit hides it, and
    // leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (payload_we) begin
            target_q[upd_idx] <= upd_target;
            if (!upd_hit) tag_q[upd_idx] <= upd_tag;
        end
    end

    // Statistics: count every resolved branch (even one dropped by clear), saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_cnt   <= '0;
            stat_miss_cnt <= '0;
        end else if (upd_valid) begin
            if (stat_br_cnt != 32'hFFFF_FFFF) stat_br_cnt <= stat_br_cnt + 32'd1;
            if (mispredict && (stat_miss_cnt != 32'hFFFF_FFFF))
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the predictor table and statistics kept below.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_if = 32'h0;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_pred_taken = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] stat_br_cnt;
    logic [31:0] stat_miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor #(.ENTRY_BITS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .btb_hit        (btb_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .clear          (clear),
        .stat_br_cnt    (stat_br_cnt),
        .stat_miss_cnt  (stat_miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (64 entries, integer counters) --------
    localparam longint MAXC = 64'hFFFF_FFFF;
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    longint      m_br;
    longint      m_miss;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == (pc >> 8));
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int j = 0; j < 64; j++) begin
            m_valid[j] = 1'b0;
            m_ctr[j]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic model_edge(input logic uv, input logic [31:0] pc, input logic t,
                              input logic [31:0] tg, input logic pt, input logic clr);
        int   i;
        logic h;
        i = m_idx(pc);
        h = m_hit(pc);
        if (uv) begin
            if (m_br < MAXC) m_br++;
            if ((pt != t) || (pt && t && h && (m_tgt[i] != tg)))
                if (m_miss < MAXC) m_miss++;
        end
        if (clr) begin
            for (int j = 0; j < 64; j++) begin
                m_valid[j] = 1'b0;
                m_ctr[j]   = 1;
            end
        end else if (uv) begin
            if (h) begin
                if (t) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else   m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                if (t) m_tgt[i] = tg;
            end else if (t) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc >> 8;
                m_tgt[i]   = tg;
                m_ctr[i]   = 2;
            end
        end
    endtask

    // Drive one update for a cycle, advance the model at the edge, end at edge+1.
    task automatic cycle(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utg, input logic upt, input logic clr);
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utg;
        upd_pred_taken = upt;
        clear          = clr;
        @(posedge clk);
        model_edge(uv, upc, ut, utg, upt, clr);
        #1;
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_pred_taken = 1'b0;
        clear          = 1'b0;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        m_reset();
        rst = 1'b0;
        pc_if = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL reset_lookup: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b0, 1'b0, 32'h104});
        end
        n_tests++;
        if ({stat_br_cnt, stat_miss_cnt} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h want %h", {stat_br_cnt, stat_miss_cnt}, 64'h0);
        end
        upd_valid = 1'b0; upd_taken = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target, stat_br_cnt} !== {1'b0, 1'b0, 32'h104, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", {btb_hit, pred_taken, pred_target, stat_br_cnt}, {1'b0, 1'b0, 32'h104, 32'h0});
        end
    endtask

    task automatic test_cold();
        pc_if = 32'h100;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL cold_lookup: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b0, 1'b0, 32'h104});
        end
        pc_if = 32'hFFFF_FFFC;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL cold_wrap: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b0, 1'b0, 32'h0});
        end
    endtask

    task automatic test_allocate();
        cycle(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 1'b0);
        pc_if = 32'h100;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL alloc_lookup: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b1, 32'h40});
        end
        n_tests++;
        if ({stat_br_cnt, stat_miss_cnt} !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL alloc_stats: got %h want %h", {stat_br_cnt, stat_miss_cnt}, {32'd1, 32'd1});
        end
    endtask

    task automatic test_saturation();
        pc_if = 32'h100;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 1'b0);
            n_tests++;
            if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h40}) begin
                n_fail++;
                $display("FAIL sat_taken_%0d: got %h want %h", k, {btb_hit, pred_taken, pred_target}, {1'b1, 1'b1, 32'h40});
            end
        end
        // From 11: first not-taken leaves 10 (still taken), second reaches 01.
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL sat_nt_1: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b1, 32'h40});
        end
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL sat_nt_2: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b0, 32'h104});
        end
        n_tests++;
        if ({stat_br_cnt, stat_miss_cnt} !== {32'd6, 32'd3}) begin
            n_fail++;
            $display("FAIL sat_stats: got %h want %h", {stat_br_cnt, stat_miss_cnt}, {32'd6, 32'd3});
        end
    endtask

    task automatic test_alias();
        cycle(1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 1'b0);
        pc_if = 32'h100;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL alias_old: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b0, 1'b0, 32'h104});
        end
        pc_if = 32'h200;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL alias_new: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b1, 32'h80});
        end
    endtask

    task automatic test_collision();
        // Entry 0x200 is at counter 10, target 0x80. Not-taken update drops it to 01.
        pc_if = 32'h200;
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b1;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL coll_same_cycle: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b1, 32'h80});
        end
        @(posedge clk);
        model_edge(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        upd_valid = 1'b0;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h204}) begin
            n_fail++;
            $display("FAIL coll_next_cycle: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b0, 32'h204});
        end
        // Taken with a new target: 01 -> 10, target replaced.
        cycle(1'b1, 32'h200, 1'b1, 32'hC0, 1'b0, 1'b0);
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'hC0}) begin
            n_fail++;
            $display("FAIL coll_retarget: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b1, 1'b1, 32'hC0});
        end
        // Correct direction but stale stored target still counts as a miss.
        cycle(1'b1, 32'h200, 1'b1, 32'h44, 1'b1, 1'b0);
        n_tests++;
        if ({btb_hit, pred_taken, pred_target, stat_br_cnt, stat_miss_cnt} !== {1'b1, 1'b1, 32'h44, 32'd10, 32'd7}) begin
            n_fail++;
            $display("FAIL target_miss: got %h want %h", {btb_hit, pred_taken, pred_target, stat_br_cnt, stat_miss_cnt}, {1'b1, 1'b1, 32'h44, 32'd10, 32'd7});
        end
    endtask

    task automatic test_clear_and_async_reset();
        cycle(1'b1, 32'h300, 1'b1, 32'h90, 1'b0, 1'b1);
        pc_if = 32'h200;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h204}) begin
            n_fail++;
            $display("FAIL clear_old: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b0, 1'b0, 32'h204});
        end
        pc_if = 32'h300;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h304}) begin
            n_fail++;
            $display("FAIL clear_dropped: got %h want %h", {btb_hit, pred_taken, pred_target}, {1'b0, 1'b0, 32'h304});
        end
        n_tests++;
        if ({stat_br_cnt, stat_miss_cnt} !== {32'd11, 32'd8}) begin
            n_fail++;
            $display("FAIL clear_stats: got %h want %h", {stat_br_cnt, stat_miss_cnt}, {32'd11, 32'd8});
        end
        // Reset lands in the middle of a pending update.
        upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h90; upd_pred_taken = 1'b0;
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        n_tests++;
        if ({stat_br_cnt, stat_miss_cnt} !== 64'h0) begin
            n_fail++;
            $display("FAIL async_rst_stats: got %h want %h", {stat_br_cnt, stat_miss_cnt}, 64'h0);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0; upd_taken = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({btb_hit, pred_taken, pred_target, stat_br_cnt, stat_miss_cnt} !== {1'b0, 1'b0, 32'h304, 64'h0}) begin
            n_fail++;
            $display("FAIL async_rst_discard: got %h want %h", {btb_hit, pred_taken, pred_target, stat_br_cnt, stat_miss_cnt}, {1'b0, 1'b0, 32'h304, 64'h0});
        end
    endtask

    function automatic logic [31:0] rand_pc();
        // Four tags over eight indices gives plenty of hits and aliasing.
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    task automatic test_random();
        logic [31:0] upc;
        logic        ut;
        logic        upt;
        for (int n = 0; n < 400; n++) begin
            upc = rand_pc();
            ut  = 1'($urandom_range(0, 1));
            upt = m_pred(upc);
            if ($urandom_range(0, 3) == 0) upt = ~upt;
            if (upt && ut && !m_hit(upc)) upt = 1'b0;
            pc_if          = rand_pc();
            upd_valid      = ($urandom_range(0, 3) != 0);
            upd_pc         = upc;
            upd_taken      = ut;
            upd_target     = $urandom & 32'hFFFF_FFFC;
            upd_pred_taken = upt;
            clear          = ($urandom_range(0, 63) == 0);
            #1;
            n_tests++;
            if ({btb_hit, pred_taken, pred_target} !== {m_hit(pc_if), m_pred(pc_if), m_next(pc_if)}) begin
                n_fail++;
                $display("FAIL rand_lookup[%0d] pc=%h: got %h want %h", n, pc_if,
                         {btb_hit, pred_taken, pred_target}, {m_hit(pc_if), m_pred(pc_if), m_next(pc_if)});
            end
            n_tests++;
            if ({stat_br_cnt, stat_miss_cnt} !== {m_br[31:0], m_miss[31:0]}) begin
                n_fail++;
                $display("FAIL rand_stats[%0d]: got %h want %h", n, {stat_br_cnt, stat_miss_cnt}, {m_br[31:0], m_miss[31:0]});
            end
            @(posedge clk);
            model_edge(upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, clear);
            #1;
        end
        upd_valid = 1'b0;
        clear     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold();
        test_allocate();
        test_saturation();
        test_alias();
        test_collision();
        test_clear_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
